rl_lj_force_collector: RTL

//  Receiving end of the LJ force pipeline's output interface (ovalid + 4*DATA_WIDTH forceoutput).
//  The force pipeline cannot stall, so this block issues credits upstream, catches every result and buffers it in a FIFO.

---
 rtl/rl_lj_force_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rl_lj_force_collector.sv
// rl_lj_force_collector: credit-issuing result catcher for the non-stallable LJ force pipeline.
// Optional build macro RL_LJ_COLLECTOR_ZERO_FILTER_EN discards all-zero (beyond-cutoff) results.
module rl_lj_force_collector #(
   parameter int DATA_WIDTH      = 32,
   parameter int FIFO_DEPTH      = 64,
   parameter int FIFO_ADDR_WIDTH = 6,
   parameter int PAIR_ID_WIDTH   = 16
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   input  logic                      in_valid,
   input  logic [4*DATA_WIDTH-1:0]   in_force,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_force_x,
   output logic [DATA_WIDTH-1:0]     out_force_y,
   output logic [DATA_WIDTH-1:0]     out_force_z,
   output logic [PAIR_ID_WIDTH-1:0]  out_pair_id,
   output logic                      err_overflow,
   output logic                      err_spurious
);

   localparam int CW = FIFO_ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [PAIR_ID_WIDTH-1:0] id;
      logic [DATA_WIDTH-1:0]    z;
      logic [DATA_WIDTH-1:0]    y;
      logic [DATA_WIDTH-1:0]    x;
   } entry_t;

   logic [CW-1:0]              inflight, inflight_nxt;
   logic [CW-1:0]              occupancy, occupancy_nxt;
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [PAIR_ID_WIDTH-1:0]   pair_id;
   logic [CW:0]                credits_used;
   entry_t                     mem [FIFO_DEPTH];
   entry_t                     wr_entry, head;

   logic accept_issue, pop, full, is_zero, spurious, retire, write, drop;
   logic unused_pad;

   assign unused_pad = ^in_force[4*DATA_WIDTH-1:3*DATA_WIDTH];

   assign wr_entry.id = pair_id;
   assign wr_entry.x  = in_force[DATA_WIDTH-1:0];
   assign wr_entry.y  = in_force[2*DATA_WIDTH-1:DATA_WIDTH];
   assign wr_entry.z  = in_force[3*DATA_WIDTH-1:2*DATA_WIDTH];

`ifdef RL_LJ_COLLECTOR_ZERO_FILTER_EN
   // Sign bit ignored so both +0.0 and -0.0 count as a beyond-cutoff result.
   assign is_zero = (wr_entry.x[DATA_WIDTH-2:0] == '0) &&
                    (wr_entry.y[DATA_WIDTH-2:0] == '0) &&
                    (wr_entry.z[DATA_WIDTH-2:0] == '0);
`else
   assign is_zero = 1'b0;
`endif

   // Credits cover both buffered and still-in-pipeline results, so any latency is safe.
   assign credits_used = {1'b0, occupancy} + {1'b0, inflight};
   assign issue_ready  = credits_used < {1'b0, DEPTH_C};

   assign out_valid    = (occupancy != '0);
   assign full         = (occupancy == DEPTH_C);
   assign accept_issue = issue_valid & issue_ready;
   assign pop          = out_valid & out_ready;
   assign spurious     = in_valid & (inflight == '0);
   assign retire       = in_valid & ~spurious;
   assign write        = in_valid & ~is_zero & (~full | pop);
   assign drop         = in_valid & ~is_zero & full & ~pop;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      inflight_nxt  = inflight;
      occupancy_nxt = occupancy;
      if (accept_issue && !retire) begin
         inflight_nxt = inflight + CW'(1);
      end else if (!accept_issue && retire) begin
         inflight_nxt = inflight - CW'(1);
      end
      if (write && !pop) begin
         occupancy_nxt = occupancy + CW'(1);
      end else if (!write && pop) begin
         occupancy_nxt = occupancy - CW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         inflight     <= '0;
         occupancy    <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         pair_id      <= '0;
         err_overflow <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         inflight  <= inflight_nxt;
         occupancy <= occupancy_nxt;
         if (write) begin
            wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
         end
         if (in_valid) begin
            pair_id <= pair_id + PAIR_ID_WIDTH'(1);
         end
         if (drop) begin
            err_overflow <= 1'b1;
         end
         if (spurious) begin
            err_spurious <= 1'b1;
         end
      end
   end

   // NOTE: the storage array is deliberately not reset; out_valid masks stale contents.
   always_ff @(posedge clock) begin
      if (write) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   assign head        = mem[rd_ptr];
   assign out_force_x = out_valid ? head.x  : '0;
   assign out_force_y = out_valid ? head.y  : '0;
   assign out_force_z = out_valid ? head.z  : '0;
   assign out_pair_id = out_valid ? head.id : '0;

endmodule
